// File: rtl/branch_predict_unit_if.sv
// Branch predict unit bus interface.
// Groups the IF-stage lookup port and the EX-stage resolve/train port.
//   if_valid, if_stall, if_pc  : fetch-side lookup request
//   if_pred_taken              : registered prediction (1-cycle latency)
//   ex_*  inputs               : instruction being resolved in EX
//   ex_is_branch/take/link/mispredict : combinational resolution results
//   perf_mispred               : saturating mispredict counter
// master = pipeline side driving requests, slave = predictor.
interface branch_predict_unit_if #(
  parameter int DATA_W = 32,
  parameter int PERF_W = 16
);
  logic              if_valid;
  logic              if_stall;
  logic [DATA_W-1:0] if_pc;
  logic              if_pred_taken;

  logic              ex_en;
  logic [5:0]        ex_opcode;
  logic [4:0]        ex_rt;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_pred_taken;
  logic              ex_is_branch;
  logic              ex_take;
  logic              ex_link;
  logic              ex_mispredict;

  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output if_valid, if_stall, if_pc,
    output ex_en, ex_opcode, ex_rt, ex_rs_data, ex_rt_data, ex_pc, ex_pred_taken,
    input  if_pred_taken, ex_is_branch, ex_take, ex_link, ex_mispredict, perf_mispred
  );

  modport slave (
    input  if_valid, if_stall, if_pc,
    input  ex_en, ex_opcode, ex_rt, ex_rs_data, ex_rt_data, ex_pc, ex_pred_taken,
    output if_pred_taken, ex_is_branch, ex_take, ex_link, ex_mispredict, perf_mispred
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit: MIPS conditional-branch evaluation in EX plus a
// branch history table of 2-bit saturating counters indexed by PC.
// Ports:
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : branch_predict_unit_if.slave (IF lookup, EX resolve, perf counter)
// The IF prediction is the MSB of the indexed counter, registered once.
// EX resolution trains the counter at idx(ex_pc); a lookup in the same
// cycle at the same index sees the pre-update value.
module branch_predict_unit #(
  parameter int         DATA_W    = 32,
  parameter int         BHT_DEPTH = 64,
  parameter int         IDX_LSB   = 2,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ
  } br_op_e;

  br_op_e            op;
  logic              link_raw;
  logic              take_raw;
  logic              eq;
  logic              rs_neg;
  logic              rs_zero;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        bht [BHT_DEPTH];
  logic              pred_q;
  logic [PERF_W-1:0] perf_q;

  // Only the index slice of each PC matters; the rest is deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

  // ---------------- decode ----------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op       = OP_NONE;
    link_raw = 1'b0;
    case (bus.ex_opcode)
      6'b000100: op = OP_BEQ;
      6'b000101: op = OP_BNE;
      6'b000110: op = OP_BLEZ;
      6'b000111: op = OP_BGTZ;
      6'b000001: begin
        case (bus.ex_rt)
          5'b00000: op = OP_BLTZ;
          5'b00001: op = OP_BGEZ;
          5'b10000: begin op = OP_BLTZ; link_raw = 1'b1; end
          5'b10001: begin op = OP_BGEZ; link_raw = 1'b1; end
          default:  op = OP_NONE;
        endcase
      end
      default: op = OP_NONE;
    endcase
  end

  // ---------------- conditions ----------------
  // Signed compares against zero reduce to the sign bit and a zero test.
  assign eq      = (bus.ex_rs_data == bus.ex_rt_data);
  assign rs_neg  = bus.ex_rs_data[DATA_W-1];
  assign rs_zero = ~|bus.ex_rs_data;

  always_comb begin
    take_raw = 1'b0;
    case (op)
      OP_BEQ:  take_raw = eq;
      OP_BNE:  take_raw = ~eq;
      OP_BLEZ: take_raw = rs_neg | rs_zero;
      OP_BGTZ: take_raw = ~rs_neg & ~rs_zero;
      OP_BLTZ: take_raw = rs_neg;
      OP_BGEZ: take_raw = ~rs_neg;
      default: take_raw = 1'b0;
    endcase
  end

  assign bus.ex_is_branch  = bus.ex_en & (op != OP_NONE);
  assign bus.ex_take       = bus.ex_en & take_raw;
  assign bus.ex_link       = bus.ex_en & link_raw;
  assign bus.ex_mispredict = bus.ex_is_branch & (bus.ex_take ^ bus.ex_pred_taken);

  // ---------------- branch history table ----------------
  assign rd_idx = bus.if_pc[IDX_LSB +: IDX_W];
  assign wr_idx = bus.ex_pc[IDX_LSB +: IDX_W];

  // NOTE: the table is a bank of flops, not a RAM, so every entry can and
  // must be reset to CNT_INIT; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (bus.ex_is_branch) begin
      if (bus.ex_take) begin
        if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
      end else begin
        if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
      end
    end
  end

  // NOTE: non-blocking assignment here means this read sees the counter value
  // from before this edge's training write, giving the no-bypass behaviour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_q <= 1'b0;
    end else if (!bus.if_stall) begin
      pred_q <= bus.if_valid & bht[rd_idx][1];
    end
  end

  // ---------------- mispredict counter ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (bus.ex_mispredict && (perf_q != {PERF_W{1'b1}})) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.if_pred_taken = pred_q;
  assign bus.perf_mispred  = perf_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit. Two instances share the same stimulus:
// one with a 16-bit mispredict counter and one with a 2-bit counter so the
// saturation point is reached. The driver predicts every cycle's outputs from
// a counter-table model and queues them; a monitor on the falling edge pops
// and compares.
module tb_branch_predict_unit;

  localparam int DATA_W    = 32;
  localparam int BHT_DEPTH = 64;
  localparam int IDX_LSB   = 2;
  localparam int CNT_INIT  = 1;

  logic clk;
  logic resetn;

  branch_predict_unit_if #(.DATA_W(DATA_W), .PERF_W(16)) bif ();
  branch_predict_unit_if #(.DATA_W(DATA_W), .PERF_W(2))  bif2 ();

  branch_predict_unit #(
    .DATA_W(DATA_W), .BHT_DEPTH(BHT_DEPTH), .IDX_LSB(IDX_LSB),
    .CNT_INIT(2'b01), .PERF_W(16)
  ) dut (.clk(clk), .resetn(resetn), .bus(bif.slave));

  branch_predict_unit #(
    .DATA_W(DATA_W), .BHT_DEPTH(BHT_DEPTH), .IDX_LSB(IDX_LSB),
    .CNT_INIT(2'b01), .PERF_W(2)
  ) dut2 (.clk(clk), .resetn(resetn), .bus(bif2.slave));

  assign bif2.if_valid      = bif.if_valid;
  assign bif2.if_stall      = bif.if_stall;
  assign bif2.if_pc         = bif.if_pc;
  assign bif2.ex_en         = bif.ex_en;
  assign bif2.ex_opcode     = bif.ex_opcode;
  assign bif2.ex_rt         = bif.ex_rt;
  assign bif2.ex_rs_data    = bif.ex_rs_data;
  assign bif2.ex_rt_data    = bif.ex_rt_data;
  assign bif2.ex_pc         = bif.ex_pc;
  assign bif2.ex_pred_taken = bif.ex_pred_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        if_valid;
    bit        if_stall;
    bit [31:0] if_pc;
    bit        ex_en;
    bit [5:0]  op;
    bit [4:0]  rt;
    bit [31:0] rs_d;
    bit [31:0] rt_d;
    bit [31:0] ex_pc;
    bit        ex_pred;
  } stim_t;

  typedef struct {
    int is_br;
    int take;
    int link;
    int misp;
    int pred;
    int perf;
    int perf2;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference state: plain integer counters 0..3, prediction bit, mispredict count.
  int m_bht [BHT_DEPTH];
  int m_pred;
  int m_perf;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int idx(input bit [31:0] pc);
    return int'((pc >> IDX_LSB) % BHT_DEPTH);
  endfunction

  // MIPS branch semantics from the instruction-set definition.
  function automatic void resolve(input stim_t s, output int br, output int tk, output int lk);
    int signed rs;
    rs = $signed(s.rs_d);
    br = 0; tk = 0; lk = 0;
    if (s.op == 6'd4)      begin br = 1; tk = int'(s.rs_d == s.rt_d); end
    else if (s.op == 6'd5) begin br = 1; tk = int'(s.rs_d != s.rt_d); end
    else if (s.op == 6'd6) begin br = 1; tk = int'(rs <= 0); end
    else if (s.op == 6'd7) begin br = 1; tk = int'(rs > 0); end
    else if (s.op == 6'd1) begin
      if (s.rt == 5'd0 || s.rt == 5'd16) begin br = 1; tk = int'(rs < 0); end
      if (s.rt == 5'd1 || s.rt == 5'd17) begin br = 1; tk = int'(rs >= 0); end
      lk = int'(s.rt == 5'd16 || s.rt == 5'd17);
    end
    if (!s.ex_en) begin br = 0; tk = 0; lk = 0; end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t beq(input bit [31:0] pc, input bit taken, input bit pred);
    stim_t s;
    s = idle();
    s.ex_en = 1; s.op = 6'd4; s.ex_pc = pc; s.ex_pred = pred;
    s.rs_d = 32'h5; s.rt_d = taken ? 32'h5 : 32'h6;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bif.if_valid      = s.if_valid;
    bif.if_stall      = s.if_stall;
    bif.if_pc         = s.if_pc;
    bif.ex_en         = s.ex_en;
    bif.ex_opcode     = s.op;
    bif.ex_rt         = s.rt;
    bif.ex_rs_data    = s.rs_d;
    bif.ex_rt_data    = s.rt_d;
    bif.ex_pc         = s.ex_pc;
    bif.ex_pred_taken = s.ex_pred;
  endtask

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = CNT_INIT;
    m_pred = 0;
    m_perf = 0;
  endtask

  // Called just after a rising edge: drive inputs, queue this cycle's
  // expectations, advance the model across the next edge, then wait for it.
  task automatic step(input stim_t s);
    int br, tk, lk, mp;
    exp_t e;
    apply(s);
    resolve(s, br, tk, lk);
    mp = int'(br != 0 && tk != int'(s.ex_pred));
    e.is_br = br; e.take = tk; e.link = lk; e.misp = mp;
    e.pred  = m_pred;
    e.perf  = m_perf;
    e.perf2 = (m_perf > 3) ? 3 : m_perf;
    sb.push_back(e);
    if (!s.if_stall) m_pred = s.if_valid ? int'(m_bht[idx(s.if_pc)] >= 2) : 0;
    if (br != 0) begin
      if (tk != 0) m_bht[idx(s.ex_pc)] = (m_bht[idx(s.ex_pc)] == 3) ? 3 : m_bht[idx(s.ex_pc)] + 1;
      else         m_bht[idx(s.ex_pc)] = (m_bht[idx(s.ex_pc)] == 0) ? 0 : m_bht[idx(s.ex_pc)] - 1;
    end
    if (mp != 0) m_perf++;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input bit [31:0] pc);
    stim_t s;
    s = idle();
    s.if_valid = 1; s.if_pc = pc;
    step(s);
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("is_branch",  int'(bif.ex_is_branch),  e.is_br);
      check("take",       int'(bif.ex_take),       e.take);
      check("link",       int'(bif.ex_link),       e.link);
      check("mispredict", int'(bif.ex_mispredict), e.misp);
      check("pred_taken", int'(bif.if_pred_taken), e.pred);
      check("perf16",     int'(bif.perf_mispred),  e.perf);
      check("perf2",      int'(bif2.perf_mispred), e.perf2);
      check("pred_taken_w2", int'(bif2.if_pred_taken), e.pred);
    end
  end

  function automatic bit [31:0] pick_data();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h5;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit [31:0] pick_pc();
    bit [31:0] pc;
    pc = 32'($urandom_range(0, 7)) << IDX_LSB;
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_FF00);
    return pc;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    bit [5:0] ops [9];
    bit [4:0] rts [5];
    ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd2, 6'd0, 6'd35};
    rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
    s.if_valid = ($urandom_range(0, 9) < 7);
    s.if_stall = ($urandom_range(0, 9) < 2);
    s.if_pc    = pick_pc();
    s.ex_en    = ($urandom_range(0, 9) < 8);
    s.op       = ops[$urandom_range(0, 8)];
    s.rt       = rts[$urandom_range(0, 4)];
    s.rs_d     = pick_data();
    s.rt_d     = ($urandom_range(0, 1) == 0) ? s.rs_d : pick_data();
    s.ex_pc    = pick_pc();
    s.ex_pred  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    resetn = 1'b0;
    apply(idle());
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state.
    step(idle());
    step(idle());

    // Decode sweep.
    s = beq(32'h800, 1, 0);                              step(s);
    s.op = 6'd5;                                         step(s);
    s = idle(); s.ex_en = 1; s.op = 6'd1; s.rt = 5'd16;
    s.rs_d = 32'h8000_0000; s.ex_pc = 32'h900;           step(s);
    s.op = 6'd2;                                         step(s);
    s.op = 6'd1; s.rt = 5'd17; s.rs_d = 32'h1; s.ex_en = 0; step(s);
    s.ex_en = 1; s.op = 6'd6; s.rs_d = 32'h0;            step(s);
    s.op = 6'd7;                                         step(s);
    s.rt = 5'd0; s.op = 6'd1; s.rs_d = 32'hFFFF_FFFF;    step(s);

    // Training and saturation at 0x100.
    repeat (4) step(beq(32'h100, 1, 0));
    lookup(32'h100);
    step(idle());
    repeat (4) step(beq(32'h100, 0, 1));
    lookup(32'h100);
    step(idle());

    // Correct resolutions leave the counter alone.
    step(beq(32'h200, 0, 0));
    step(beq(32'h200, 1, 1));

    // Same-index collision at 0x40 (counter at CNT_INIT).
    s = beq(32'h40, 1, 0); s.if_valid = 1; s.if_pc = 32'h40; step(s);
    lookup(32'h40);
    step(idle());

    // Aliasing: 0x004 and 0x104 share index 1.
    repeat (2) step(beq(32'h004, 1, 1));
    lookup(32'h104);
    lookup(32'h004);

    // Stall holds the prediction while the PC moves.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.if_stall = 1; s.if_valid = 1'(i);
      s.if_pc = 32'h100 + 32'(i * 4); step(s);
    end
    s = idle(); s.if_valid = 0; step(s);
    step(idle());

    // Randomised traffic.
    for (int i = 0; i < 400; i++) step(rand_stim());

    // Reset asserted with a training update pending.
    s = beq(32'h004, 0, 1); s.if_valid = 1; s.if_pc = 32'h004;
    apply(s);
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply(idle());
    resetn = 1'b1;
    for (int i = 0; i < BHT_DEPTH; i++) lookup(32'(i) << IDX_LSB);
    step(idle());

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch-condition logic.
- Keeps the combinational MIPS conditional-branch evaluation and adds a branch history table (BHT) of 2-bit saturating counters, indexed by PC.
- IF stage gets a registered taken/not-taken prediction. EX stage resolves the branch, flags misprediction and trains the BHT.
- Includes a saturating mispredict performance counter.

Parameters:
- DATA_W, 32, width of rs/rt operands and PC.
- BHT_DEPTH, 64, number of counters; power of two, 2 to 1024.
- IDX_LSB, 2, lowest PC bit used for the index; index = pc[IDX_LSB +: log2(BHT_DEPTH)].
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).
- PERF_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- if_valid  in  1  IF lookup request this cycle.
- if_stall  in  1  hold the IF prediction output.
- if_pc  in  DATA_W  fetch PC for lookup.
- if_pred_taken  out  1  registered prediction for the previous cycle's if_pc.
- ex_en  in  1  EX instruction valid (not squashed).
- ex_opcode  in  6  instruction opcode.
- ex_rt  in  5  rt field (REGIMM sub-op).
- ex_rs_data  in  DATA_W  rs operand.
- ex_rt_data  in  DATA_W  rt operand.
- ex_pc  in  DATA_W  PC of the EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_is_branch  out  1  opcode/rt decodes to a supported conditional branch (gated by ex_en).
- ex_take  out  1  branch resolved taken.
- ex_link  out  1  bltzal/bgezal (gated by ex_en).
- ex_mispredict  out  1  ex_is_branch & (ex_take != ex_pred_taken).
- perf_mispred  out  PERF_W  saturating count of mispredicts.

Behaviour:
- Decode, combinational:
  - beq 000100, bne 000101, blez 000110, bgtz 000111.
  - REGIMM 000001 with rt = 00000 bltz, 00001 bgez, 10000 bltzal, 10001 bgezal.
  - Any other opcode/rt gives ex_is_branch = 0.
- Conditions, combinational:
  - beq: eq. bne: !eq.
  - bgtz/blez: signed rs > 0 / <= 0.
  - bgez/bgezal: signed rs >= 0. bltz/bltzal: signed rs < 0.
  - All signed comparisons are DATA_W-bit two's complement.
- ex_take, ex_link, ex_is_branch and ex_mispredict are combinational and all 0 when ex_en = 0.
- Prediction read:
  - On a clock edge with if_valid = 1 and if_stall = 0: if_pred_taken <= counter[idx(if_pc)][1].
  - if_valid = 0 and if_stall = 0: if_pred_taken <= 0.
  - if_stall = 1: if_pred_taken holds, regardless of if_valid.
  - Latency is 1 cycle.
- Training:
  - On a clock edge with ex_is_branch = 1, counter[idx(ex_pc)] is incremented if ex_take, else decremented.
  - Counters saturate at 2'b11 and 2'b00.
  - Non-branches and ex_en = 0 never write.
- Same-cycle read/write to the same index: the read samples the pre-update counter (no bypass). The new value is visible from the following lookup.
- Different-index read and write in the same cycle proceed independently.
- perf_mispred increments on each edge where ex_mispredict = 1 and sticks at all-ones.
- Reset, asynchronous, resetn low:
  - All counters = CNT_INIT; if_pred_taken = 0; perf_mispred = 0.
  - Reset asserted mid-operation aborts any pending update immediately.
  - First lookup after release sees CNT_INIT.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. The prediction is the MSB.

Test Plan:
- Decode sweep:
  - ex_en = 1, beq, rs = rt = 0x5 -> take = 1, link = 0.
  - bne, same operands -> take = 0.
  - REGIMM rt = 10000, rs = 0x80000000 -> take = 1, link = 1.
  - Opcode 000010 -> is_branch = 0, take = 0.
  - ex_en = 0 with bgezal -> all outputs 0.
- Training/saturation:
  - Repeated taken beq at ex_pc = 0x100, ex_pred_taken = 0 -> counter 01, 10, 11, 11.
  - Lookup if_pc = 0x100 -> if_pred_taken = 1 one cycle later.
  - Four not-taken -> counter at 00, prediction 0.
- Mispredict and perf counter:
  - 3 mispredicts and 2 correct resolutions -> perf_mispred = 3.
  - With PERF_W = 2 and 5 mispredicts -> perf_mispred = 3 (saturated).
- Same-index collision:
  - Counter at 01; same cycle: taken update at 0x40 and lookup if_pc = 0x40 -> if_pred_taken = 0.
  - Next lookup -> 1.
- Aliasing/index: BHT_DEPTH = 64, IDX_LSB = 2; train 0x004 taken twice -> lookup 0x104 also predicts 1 (same index 1).
- Stall and reset:
  - if_stall = 1 holds if_pred_taken across 3 cycles while if_pc changes.
  - resetn pulsed low mid-training -> perf_mispred = 0 and all lookups return CNT_INIT[1] = 0.
